long_press_detect: RTL
======================

# long_press_detect

Parametrised multi-channel push-button front end: it synchronises and debounces each raw button input, then classifies every press. A release before the hold time gives a one-cycle short pulse. Holding the button for the hold time gives a long-press pulse plus a level that stays high until release. The block sits between the board buttons and the control FSMs, replacing the per-button fixed one-second hold detectors, and adds reset, debounce, short-press reporting, clear and optional auto-repeat.

## Interface
- CHANNELS, 5: number of independent button channels.
- HOLD_CYCLES, 100_000_000: cycles of debounced press before a long press is declared (1 s at 100 MHz); must be ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000: consecutive cycles of a new synchronised level before `pressed` follows it; must be ≥ 1.
- REPEAT_CYCLES, 25_000_000: auto-repeat period while held; used only with the repeat feature.
- CNT_W, 27: counter width; must hold the largest of the three cycle parameters.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_in  in  CHANNELS  raw, asynchronous button levels, active-high.
- clear  in  1  synchronous; aborts all channels.
- pressed  out  CHANNELS  debounced button level.
- short_pulse  out  CHANNELS  one-cycle strobe: the button was released before the hold time.
- long_pulse  out  CHANNELS  one-cycle strobe when the hold time is reached, and on each repeat.
- long_level  out  CHANNELS  high from hold time reached until release.

## Operation
- Each channel is independent and identical; there is no cross-channel interaction except `clear`.
- Synchroniser: two flops per channel.
- Debounce: a counter increments while the synchronised level ≠ `pressed`, and resets to 0 when they are equal. When the counter reaches DEBOUNCE_CYCLES−1 and the levels still differ, `pressed` toggles on the next edge and the counter returns to 0.
- Per-channel FSM states: IDLE, PRESS, HELD, WAIT_REL.
- IDLE: if `pressed`=1, go to PRESS and set hold_cnt=0.
- PRESS, `pressed`=0: go to IDLE and assert short_pulse.
- PRESS, hold_cnt=HOLD_CYCLES−1: go to HELD, assert long_pulse, set long_level=1.
- PRESS, otherwise: hold_cnt+1.
- HELD, `pressed`=0: go to IDLE, set long_level=0. No short_pulse is generated.
- WAIT_REL: go to IDLE once `pressed`=0. No pulses are generated.
- `clear`=1: every FSM goes to WAIT_REL and all pulses and long_level drop to 0 on the next edge. This has priority over every other transition. Debounce state is unaffected.
- Counters never wrap. hold_cnt stops at HOLD_CYCLES−1; the repeat counter stops at REPEAT_CYCLES−1.

## Timing
- Reset (rst_n=0): every output is 0, all FSMs are IDLE, and all counters and synchroniser flops are 0. This holds immediately, whatever the state mid-operation.
- btn_in edge to `pressed` edge: 2 + DEBOUNCE_CYCLES cycles, provided btn_in stays stable.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no change on `pressed`.
- `pressed` rise to long_pulse/long_level rise: HOLD_CYCLES + 1 cycles. One cycle enters PRESS; then HOLD_CYCLES counting cycles.
- `pressed` fall to short_pulse, or to long_level fall: 1 cycle.
- All outputs are registered. Pulses are exactly one cycle wide.
- If `pressed` falls in the same cycle that hold_cnt reaches HOLD_CYCLES−1, the release wins: short_pulse is asserted and no long_pulse occurs.
- If `clear` arrives in the same cycle as a release or a hold expiry, `clear` wins and no pulse is generated.

## Configuration
- HOLD_REPEAT_EN defined:
  - In HELD, a repeat counter starts at 0 on entry and increments each cycle.
  - At REPEAT_CYCLES−1 it asserts long_pulse for one cycle and reloads to 0.
  - Repeat pulses therefore occur every REPEAT_CYCLES cycles after the first long_pulse, until release or `clear`.
- HOLD_REPEAT_EN undefined:
  - No repeat counter is built and REPEAT_CYCLES is ignored.
  - long_pulse fires exactly once per held press.

## Test plan
Bench parameters: CHANNELS=2, HOLD_CYCLES=20, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
- Reset: hold rst_n=0 with btn_in=2'b11 → all outputs stay 0. Release reset with btn_in=0 → all outputs stay 0.
- Short press: btn_in[0]=1 for 15 cycles, then 0 → pressed[0] rises 6 cycles after the press. short_pulse[0] is a single cycle, 7 cycles after btn_in falls. long_pulse stays 0.
- Long press: btn_in[0]=1 for 60 cycles → long_pulse[0] one cycle and long_level[0] rising 27 cycles after the btn_in rise. long_level falls 7 cycles after btn_in falls. No short_pulse.
- Glitch: btn_in[1] high for 3 cycles → pressed[1] never rises and no pulses occur.
- Clear: assert clear for one cycle, 10 cycles into a held press on channel 0 → no pulses for the rest of that press. A subsequent 15-cycle press produces a normal short_pulse.
- Repeat, with HOLD_REPEAT_EN defined: hold channel 1 for 60 cycles → long_pulse[1] at cycle 27, then at 35, 43, 51, 59. Without the macro → only the pulse at cycle 27.

Source files
------------

// File: rtl/long_press_detect.sv
// Multi-channel push-button front end: synchronise, debounce, then classify short/long presses.
// Optional auto-repeat while held is built when the macro HOLD_REPEAT_EN is defined.
module long_press_detect #(
  parameter int unsigned CHANNELS        = 5,
  parameter int unsigned HOLD_CYCLES     = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_CYCLES   = 25_000_000,
  parameter int unsigned CNT_W           = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  input  logic                clear,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] short_pulse,
  output logic [CHANNELS-1:0] long_pulse,
  output logic [CHANNELS-1:0] long_level
);

  typedef enum logic [1:0] {StIdle, StPress, StHeld, StWaitRel} state_e;

  logic [CHANNELS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

`ifndef HOLD_REPEAT_EN
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d, hold_cnt_q, hold_cnt_d;
    logic             pressed_q, pressed_d;
    logic             short_q, short_d, long_q, long_d, level_q, level_d;
    state_e           state_q, state_d;
`ifdef HOLD_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    // Counter only runs while the synchronised level disagrees with the debounced one.
    always_comb begin
      db_cnt_d  = '0;
      pressed_d = pressed_q;
      if (sync2_q[c] != pressed_q) begin
        if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          pressed_d = ~pressed_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      short_d    = 1'b0;
      long_d     = 1'b0;
      level_d    = level_q;
`ifdef HOLD_REPEAT_EN
      rep_cnt_d  = rep_cnt_q;
`endif
      if (clear) begin
        state_d = StWaitRel;
        level_d = 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (pressed_q) begin
              state_d    = StPress;
              hold_cnt_d = '0;
            end
          end
          StPress: begin
            // Release takes precedence over a hold expiry in the same cycle.
            if (!pressed_q) begin
              state_d = StIdle;
              short_d = 1'b1;
            end else if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
              state_d = StHeld;
              long_d  = 1'b1;
              level_d = 1'b1;
`ifdef HOLD_REPEAT_EN
              rep_cnt_d = '0;
`endif
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
          StHeld: begin
            if (!pressed_q) begin
              state_d = StIdle;
              level_d = 1'b0;
            end else begin
`ifdef HOLD_REPEAT_EN
              if (rep_cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
                long_d    = 1'b1;
                rep_cnt_d = '0;
              end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
              end
`endif
            end
          end
          StWaitRel: begin
            if (!pressed_q) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q   <= '0;
        pressed_q  <= 1'b0;
        state_q    <= StIdle;
        hold_cnt_q <= '0;
        short_q    <= 1'b0;
        long_q     <= 1'b0;
        level_q    <= 1'b0;
`ifdef HOLD_REPEAT_EN
        rep_cnt_q  <= '0;
`endif
      end else begin
        db_cnt_q   <= db_cnt_d;
        pressed_q  <= pressed_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        short_q    <= short_d;
        long_q     <= long_d;
        level_q    <= level_d;
`ifdef HOLD_REPEAT_EN
        rep_cnt_q  <= rep_cnt_d;
`endif
      end
    end

    assign pressed[c]     = pressed_q;
    assign short_pulse[c] = short_q;
    assign long_pulse[c]  = long_q;
    assign long_level[c]  = level_q;
  end

endmodule
